// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the byte controller and the on-chip target block.
// It holds the FSM state encoding, the phase indices and the ACK/NACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    WDATA,
    DACK,
    RDATA,
    MACK,
    STOP
  } i2c_state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Cells in which the controller itself drives SDA with shift-register data.
  function automatic logic is_tx_cell(input i2c_state_t s);
    return (s == ADDR) || (s == WDATA);
  endfunction

  // Index of the final quarter phase of each state.
  function automatic logic [1:0] last_phase(input i2c_state_t s);
    case (s)
      START:   return PH1;
      STOP:    return PH2;
      default: return PH3;
    endcase
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period tick generator. It produces one tick every CLK_DIV cycles.
// It is cleared while the controller is idle and is held at zero during clock stretching.
module i2c_qtick #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = ~clr & ~hold & (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || hold) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C initiator. Each command runs START, address+R/W, one data byte and STOP.
// The pads are open drain, and SCL timing comes from a quarter-period tick.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  i2c_state_t state_reg, state_next;
  logic [1:0] phase_reg, phase_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       rw_reg, rw_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       ack_err_reg, ack_err_next;
  logic       done_reg, done_next;

  logic tick;
  logic stretch_hold;
  logic is_idle;

  assign is_idle = (state_reg == IDLE);
  // A target may hold SCL low only while we have released it.
  assign stretch_hold = ~is_idle & ~scl_oe & ~scl_in;

  i2c_qtick #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (is_idle),
    .hold  (stretch_hold),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      phase_reg   <= PH0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      rw_reg      <= 1'b0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      ack_err_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      rw_reg      <= rw_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      ack_err_reg <= ack_err_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    rw_next      = rw_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    ack_err_next = ack_err_reg;
    done_next    = 1'b0;

    if (is_idle) begin
      if (cmd_valid) begin
        state_next   = START;
        phase_next   = PH0;
        shift_next   = {cmd_addr, cmd_rw};
        rw_next      = cmd_rw;
        wdata_next   = cmd_wdata;
        ack_err_next = 1'b0;
      end
    end else if (tick) begin
      if (phase_reg != last_phase(state_reg)) begin
        phase_next = phase_reg + 2'd1;
      end else begin
        phase_next = PH0;
        case (state_reg)
          START: begin
            state_next   = ADDR;
            bit_cnt_next = 3'd7;
          end
          ADDR, WDATA, RDATA: begin
            // The same shift register serialises tx bits and collects rx bits.
            shift_next = {shift_reg[6:0], (state_reg == RDATA) ? sda_in : 1'b0};
            if (bit_cnt_reg == 3'd0) begin
              if (state_reg == ADDR) begin
                state_next = AACK;
              end else if (state_reg == WDATA) begin
                state_next = DACK;
              end else begin
                state_next = MACK;
                rdata_next = {shift_reg[6:0], sda_in};
              end
            end else begin
              bit_cnt_next = bit_cnt_reg - 3'd1;
            end
          end
          AACK: begin
            if (sda_in == NACK) begin
              ack_err_next = 1'b1;
              state_next   = STOP;
            end else if (rw_reg) begin
              state_next   = RDATA;
              bit_cnt_next = 3'd7;
            end else begin
              state_next   = WDATA;
              shift_next   = wdata_reg;
              bit_cnt_next = 3'd7;
            end
          end
          DACK: begin
            ack_err_next = (sda_in == NACK);
            state_next   = STOP;
          end
          MACK: begin
            state_next = STOP;
          end
          STOP: begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_reg)
      START: begin
        sda_oe = 1'b1;
        scl_oe = (phase_reg == PH1);
      end
      ADDR, WDATA, AACK, DACK, RDATA, MACK: begin
        scl_oe = ~phase_reg[1];
        // Receive slots and the master NACK after the read byte leave SDA released.
        sda_oe = is_tx_cell(state_reg) & ~shift_reg[7];
      end
      STOP: begin
        scl_oe = (phase_reg == PH0);
        sda_oe = (phase_reg != PH2);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign busy    = ~is_idle;
  assign done    = done_reg;
  assign ack_err = ack_err_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte. A behavioural target on the pads answers each command.
// Expected results are queued per command and compared when done pulses.
module tb_i2c_master_byte;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  logic       scl_in, sda_in, scl_oe, sda_oe;

  logic slave_scl_hold = 1'b0;
  logic slave_sda_low  = 1'b0;

  assign scl_in = ~(scl_oe | slave_scl_hold);
  assign sda_in = ~(sda_oe | slave_sda_low);

  i2c_master_byte #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .rdata     (rdata),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Target model configuration
  logic       slave_nack_addr = 1'b0;
  logic [7:0] slave_rdata = 8'h00;
  int         stretch_cell = -1;
  int         stretch_len = 50;

  // Target model observations
  int   rise_idx = 0;
  logic cap [0:19];
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;
  int   hold_left = 0;

  function automatic logic slave_drive(input int n);
    if (n == 8) return ~slave_nack_addr;
    if (n >= 9 && n <= 16 && cap[7] === 1'b1 && !slave_nack_addr) return ~slave_rdata[16-n];
    if (n == 17 && cap[7] === 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic scl_now, sda_now;
    if (hold_left > 0) begin
      hold_left = hold_left - 1;
      if (hold_left == 0) slave_scl_hold = 1'b0;
    end
    if (prev_scl_oe && !scl_oe && rise_idx == stretch_cell && hold_left == 0) begin
      slave_scl_hold = 1'b1;
      hold_left = stretch_len;
      stretch_cell = -1;
    end
    scl_now = ~(scl_oe | slave_scl_hold);
    sda_now = ~(sda_oe | slave_sda_low);
    if (prev_scl && scl_now && prev_sda && !sda_now) begin
      rise_idx = 0;
    end else if (!prev_scl && scl_now) begin
      if (rise_idx < 20) cap[rise_idx] = sda_now;
      rise_idx = rise_idx + 1;
    end else if (prev_scl && !scl_now) begin
      slave_sda_low = slave_drive(rise_idx);
    end
    prev_scl    = scl_now;
    prev_sda    = ~(sda_oe | slave_sda_low);
    prev_scl_oe = scl_oe;
  end

  typedef struct {
    int         done_cyc;
    logic       ack_err;
    logic       rd;
    logic [7:0] rdata;
    logic [7:0] addr_byte;
    logic [7:0] wdata;
    int         rises;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cap_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap[base+i];
    return b;
  endfunction

  // Places a command on the bus for one cycle and queues its expected outcome.
  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w,
                       input logic nack, input logic [7:0] rd_byte, input int extra,
                       input logic keep_valid);
    exp_t e;
    int cells;
    @(negedge clk);
    cmd_addr  = a;
    cmd_rw    = r;
    cmd_wdata = w;
    cmd_valid = 1'b1;
    cells = nack ? 9 : 18;
    e.done_cyc  = cyc + 1 + (2 + cells * 4 + 3) * CLK_DIV + extra;
    e.ack_err   = nack;
    e.rd        = r & ~nack;
    e.rdata     = rd_byte;
    e.addr_byte = {a, r};
    e.wdata     = w;
    e.rises     = cells + 1;
    sb.push_back(e);
    @(negedge clk);
    if (!keep_valid) cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic check_done();
    exp_t e;
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("done_cycle", cyc, e.done_cyc);
    chk("ack_err", ack_err, e.ack_err);
    chk("busy_at_done", busy, 0);
    chk("addr_bits", cap_byte(0), e.addr_byte);
    chk("scl_rises", rise_idx, e.rises);
    if (e.rd) begin
      chk("rdata", rdata, e.rdata);
      chk("mack_released", cap[17], 1);
    end else if (!e.ack_err) begin
      chk("wdata_bits", cap_byte(9), e.wdata);
      chk("dack_seen", cap[17], 0);
    end
    $display("[TB] txn addr_byte=%02h done_cyc=%0d ack_err=%b rdata=%02h", e.addr_byte, cyc, ack_err, rdata);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1);
    if (done) begin
      check_done();
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Write with ACKs
    issue(7'h3A, 1'b0, 8'hA5, 1'b0, 8'h00, 0, 1'b0);
    wait_done(2000);

    // Read, target returns 0xC3
    slave_rdata = 8'hC3;
    issue(7'h50, 1'b1, 8'h00, 1'b0, 8'hC3, 0, 1'b0);
    wait_done(2000);

    // Address NACK
    slave_nack_addr = 1'b1;
    issue(7'h22, 1'b0, 8'h77, 1'b1, 8'h00, 0, 1'b0);
    wait_done(2000);
    slave_nack_addr = 1'b0;

    // Clock stretch of 50 cycles in ADDR bit 3
    stretch_cell = 3;
    issue(7'h3A, 1'b0, 8'hA5, 1'b0, 8'h00, 50, 1'b0);
    wait_done(2000);

    // Reset during ADDR bit 4
    @(negedge clk);
    cmd_addr = 7'h3A; cmd_rw = 1'b0; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (rise_idx == 4 && !scl_in) break;
      @(negedge clk);
    end
    chk("reached_addr_bit4", (rise_idx == 4), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_scl_oe", scl_oe, 0);
    chk("abort_sda_oe", sda_oe, 0);
    chk("abort_busy", busy, 0);
    ndone = 0;
    for (int k = 0; k < 400; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    // Normal command after the abort
    issue(7'h11, 1'b0, 8'h5A, 1'b0, 8'h00, 0, 1'b0);
    wait_done(2000);

    // Back-to-back: cmd_valid held across the first done
    issue(7'h3A, 1'b0, 8'hA5, 1'b0, 8'h00, 0, 1'b1);
    begin
      exp_t e2;
      e2 = sb[sb.size()-1];
      e2.done_cyc = e2.done_cyc + (2 + 18 * 4 + 3) * CLK_DIV + 1;
      sb.push_back(e2);
    end
    ndone = 0;
    for (int k = 0; k < 618; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check_done();
        if (ndone == 2) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_done_count", ndone, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
